// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline control blocks: FSM states, the
// register-specifier width and the bundled pipeline-control word.
package mips_pkg;

    localparam int REG_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic stall_if_id;
        logic flush_if_id;
        logic stall_id_ex;
        logic flush_id_ex;
        logic stall_ex_mem;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_IDLE     = 6'b100000;
    localparam hazard_ctrl_t CTRL_MEM_HOLD = 6'b010101;
    localparam hazard_ctrl_t CTRL_REDIRECT = 6'b101010;
    localparam hazard_ctrl_t CTRL_BUBBLE   = 6'b010010;

    // A register that is being cleared must never also be held.
    function automatic hazard_ctrl_t flush_wins(input hazard_ctrl_t c);
        hazard_ctrl_t r;
        r             = c;
        r.stall_if_id = c.stall_if_id & ~c.flush_if_id;
        r.stall_id_ex = c.stall_id_ex & ~c.flush_id_ex;
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_chk.sv
// Property checker for the hazard controller's stall/flush outputs.
module pipe_hazard_ctrl_chk (
    input logic Clk,
    input logic Reset,
    input logic Stall_IF_ID,
    input logic Flush_IF_ID,
    input logic Stall_ID_EX,
    input logic Flush_ID_EX
);

    a_if_id_excl: assert property (@(posedge Clk) disable iff (Reset)
        !(Stall_IF_ID && Flush_IF_ID));

    a_id_ex_excl: assert property (@(posedge Clk) disable iff (Reset)
        !(Stall_ID_EX && Flush_ID_EX));

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear;
// it holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall scheduler for the 5-stage MIPS pipeline: memory wait,
// branch/jump redirect and load-use, resolved in that priority order.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W      = mips_pkg::REG_W,
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] Rt_EX,
    input  logic             BranchTaken_EX,
    input  logic             Jump_EX,
    input  logic             MemReq_MEM,
    input  logic             MemReady_MEM,
    output logic             PCWrite,
    output logic             Stall_IF_ID,
    output logic             Flush_IF_ID,
    output logic             Stall_ID_EX,
    output logic             Flush_ID_EX,
    output logic             Stall_EX_MEM,
    output logic             LoadUse,
    output logic             Timeout,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int                WCNT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_LIMIT);
    localparam logic [WCNT_W-1:0] WAIT_ONE = WCNT_W'(1);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [WCNT_W-1:0] wait_cnt_d;
    logic              load_use_q;
    logic              load_use_d;
    logic              timeout_q;
    logic              timeout_d;

    hazard_ctrl_t      ctrl_s;
    logic              mem_stall_s;
    logic              redirect_s;
    logic              load_use_hit_s;
    logic              flush_inc_s;

    // Raw hazard terms
    always_comb begin
        redirect_s     = BranchTaken_EX | Jump_EX;
        load_use_hit_s = MemRead_EX && (Rt_EX != {REG_W{1'b0}}) &&
                         ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
        if (state_q == MEM_WAIT) begin
            // Once waiting, only the ready handshake releases the pipeline.
            mem_stall_s = !MemReady_MEM;
        end else begin
            mem_stall_s = MemReq_MEM && !MemReady_MEM;
        end
    end

    // Priority resolution of the control word and next-state logic
    always_comb begin
        ctrl_s      = CTRL_IDLE;
        state_d     = RUN;
        wait_cnt_d  = {WCNT_W{1'b0}};
        load_use_d  = 1'b0;
        timeout_d   = timeout_q;
        flush_inc_s = 1'b0;
        if (Reset) begin
            timeout_d = 1'b0;
        end else if (mem_stall_s) begin
            ctrl_s     = CTRL_MEM_HOLD;
            wait_cnt_d = (state_q == MEM_WAIT) ? (wait_cnt_q + WAIT_ONE) : WAIT_ONE;
            if (wait_cnt_d >= WAIT_MAX) begin
                timeout_d = 1'b1;
                state_d   = RUN;
            end else begin
                state_d   = MEM_WAIT;
            end
        end else if (redirect_s) begin
            ctrl_s      = CTRL_REDIRECT;
            flush_inc_s = 1'b1;
        end else if (load_use_hit_s) begin
            ctrl_s     = CTRL_BUBBLE;
            load_use_d = 1'b1;
        end else begin
            ctrl_s = CTRL_IDLE;
        end
        ctrl_s = flush_wins(ctrl_s);
    end

    // Controller state and registered status
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= RUN;
            wait_cnt_q <= {WCNT_W{1'b0}};
            load_use_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            load_use_q <= load_use_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .clr   (Reset),
        .inc   (!ctrl_s.pc_write),
        .count (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .clr   (Reset),
        .inc   (flush_inc_s),
        .count (FlushCnt)
    );

    pipe_hazard_ctrl_chk u_chk (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall_IF_ID (Stall_IF_ID),
        .Flush_IF_ID (Flush_IF_ID),
        .Stall_ID_EX (Stall_ID_EX),
        .Flush_ID_EX (Flush_ID_EX)
    );

    assign PCWrite      = ctrl_s.pc_write;
    assign Stall_IF_ID  = ctrl_s.stall_if_id;
    assign Flush_IF_ID  = ctrl_s.flush_if_id;
    assign Stall_ID_EX  = ctrl_s.stall_id_ex;
    assign Flush_ID_EX  = ctrl_s.flush_id_ex;
    assign Stall_EX_MEM = ctrl_s.stall_ex_mem;
    assign LoadUse      = load_use_q;
    assign Timeout      = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int WAIT_LIMIT = 4;
    localparam int CNT_W      = 4;
    localparam int MAXC       = (1 << CNT_W) - 1;

    // {PCWrite, Stall_IF_ID, Flush_IF_ID, Stall_ID_EX, Flush_ID_EX, Stall_EX_MEM}
    localparam logic [5:0] C_IDLE   = 6'b100000;
    localparam logic [5:0] C_MEM    = 6'b010101;
    localparam logic [5:0] C_REDIR  = 6'b101010;
    localparam logic [5:0] C_BUBBLE = 6'b010010;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [4:0]       Rs_ID, Rt_ID, Rt_EX;
    logic             UsesRt_ID, MemRead_EX, BranchTaken_EX, Jump_EX;
    logic             MemReq_MEM, MemReady_MEM;
    logic             PCWrite, Stall_IF_ID, Flush_IF_ID, Stall_ID_EX, Flush_ID_EX, Stall_EX_MEM;
    logic             LoadUse, Timeout;
    logic [CNT_W-1:0] StallCnt, FlushCnt;
    logic [5:0]       act;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: is the pipeline frozen on memory, and for how long
    bit m_waiting;
    int m_waited;
    bit m_lu, m_to;
    int m_sc, m_fc;

    pipe_hazard_ctrl #(.REG_W(5), .WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
        .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .BranchTaken_EX(BranchTaken_EX),
        .Jump_EX(Jump_EX), .MemReq_MEM(MemReq_MEM), .MemReady_MEM(MemReady_MEM),
        .PCWrite(PCWrite), .Stall_IF_ID(Stall_IF_ID), .Flush_IF_ID(Flush_IF_ID),
        .Stall_ID_EX(Stall_ID_EX), .Flush_ID_EX(Flush_ID_EX), .Stall_EX_MEM(Stall_EX_MEM),
        .LoadUse(LoadUse), .Timeout(Timeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    assign act = {PCWrite, Stall_IF_ID, Flush_IF_ID, Stall_ID_EX, Flush_ID_EX, Stall_EX_MEM};

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit frozen();
        if (m_waiting) return !MemReady_MEM;
        return MemReq_MEM && !MemReady_MEM;
    endfunction

    function automatic bit lu_match();
        return MemRead_EX && (Rt_EX != 5'd0) &&
               ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
    endfunction

    function automatic logic [5:0] exp_ctrl();
        if (Reset)                        return C_IDLE;
        if (frozen())                     return C_MEM;
        if (BranchTaken_EX || Jump_EX)    return C_REDIR;
        if (lu_match())                   return C_BUBBLE;
        return C_IDLE;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic mr, input logic [4:0] rtex,
                         input logic br, input logic jp, input logic req, input logic rdy);
        @(negedge Clk);
        Reset = rst; Rs_ID = rs; Rt_ID = rt; UsesRt_ID = uses; MemRead_EX = mr;
        Rt_EX = rtex; BranchTaken_EX = br; Jump_EX = jp; MemReq_MEM = req; MemReady_MEM = rdy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock edge and move the model forward with it.
    task automatic tick();
        logic [5:0] e;
        bit         fr;
        e  = exp_ctrl();
        fr = frozen();
        @(posedge Clk);
        if (Reset) begin
            m_waiting = 1'b0; m_waited = 0; m_lu = 1'b0; m_to = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            m_lu = 1'b0;
            if (!e[5]) m_sc = sat(m_sc + 1);
            if (fr) begin
                m_waited = m_waiting ? m_waited + 1 : 1;
                if (m_waited >= WAIT_LIMIT) begin
                    m_to = 1'b1;
                    m_waiting = 1'b0;
                end else begin
                    m_waiting = 1'b1;
                end
            end else begin
                m_waiting = 1'b0;
                if (BranchTaken_EX || Jump_EX) m_fc = sat(m_fc + 1);
                else if (lu_match())           m_lu = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", act, C_IDLE); end
        tick();
        n_checks++;
        if ({LoadUse, Timeout, StallCnt, FlushCnt} !== {2'b00, {(2*CNT_W){1'b0}}}) begin
            n_fail++; $display("FAIL reset_regs: got lu=%b to=%b sc=%0d fc=%0d expected all 0", LoadUse, Timeout, StallCnt, FlushCnt);
        end
    endtask

    task automatic test_load_use();
        drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_BUBBLE) begin n_fail++; $display("FAIL load_use_ctrl: got %b expected %b", act, C_BUBBLE); end
        tick();
        n_checks++;
        if (LoadUse !== 1'b1 || StallCnt !== 4'd1) begin
            n_fail++; $display("FAIL load_use_regs: got lu=%b sc=%0d expected lu=1 sc=1", LoadUse, StallCnt);
        end
        idle();
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL load_use_once: got %b expected %b", act, C_IDLE); end
        tick();
        n_checks++;
        if (LoadUse !== 1'b0) begin n_fail++; $display("FAIL load_use_clear: got %b expected 0", LoadUse); end
    endtask

    task automatic test_no_hazard();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL load_r0: got %b expected %b", act, C_IDLE); end
        tick();
        drive(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL rt_not_src: got %b expected %b", act, C_IDLE); end
        tick();
        drive(1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_BUBBLE) begin n_fail++; $display("FAIL rt_src: got %b expected %b", act, C_BUBBLE); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_REDIR) begin n_fail++; $display("FAIL redirect_ctrl: got %b expected %b", act, C_REDIR); end
        tick();
        n_checks++;
        if (FlushCnt !== 4'd1 || LoadUse !== 1'b0 || StallCnt !== 4'd0) begin
            n_fail++; $display("FAIL redirect_regs: got fc=%0d lu=%b sc=%0d expected fc=1 lu=0 sc=0", FlushCnt, LoadUse, StallCnt);
        end
        drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_REDIR) begin n_fail++; $display("FAIL jump_ctrl: got %b expected %b", act, C_REDIR); end
        tick();
        n_checks++;
        if (FlushCnt !== 4'd2) begin n_fail++; $display("FAIL jump_cnt: got %0d expected 2", FlushCnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (act !== C_MEM) begin n_fail++; $display("FAIL mem_wait_ctrl[%0d]: got %b expected %b", i, act, C_MEM); end
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL mem_release: got %b expected %b", act, C_IDLE); end
        tick();
        n_checks++;
        if (StallCnt !== 4'd3 || FlushCnt !== 4'd0 || Timeout !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_cnt: got sc=%0d fc=%0d to=%b expected sc=3 fc=0 to=0", StallCnt, FlushCnt, Timeout);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (act !== C_MEM) begin n_fail++; $display("FAIL timeout_stall[%0d]: got %b expected %b", i, act, C_MEM); end
            tick();
            n_checks++;
            if (Timeout !== (i == WAIT_LIMIT - 1)) begin
                n_fail++; $display("FAIL timeout_flag[%0d]: got %b expected %b", i, Timeout, (i == WAIT_LIMIT - 1));
            end
        end
        idle();
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL timeout_release: got %b expected %b", act, C_IDLE); end
        tick();
        n_checks++;
        if (Timeout !== 1'b1 || StallCnt !== 4'(WAIT_LIMIT)) begin
            n_fail++; $display("FAIL timeout_sticky: got to=%b sc=%0d expected to=1 sc=%0d", Timeout, StallCnt, WAIT_LIMIT);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL rst_wait_ctrl: got %b expected %b", act, C_IDLE); end
        tick();
        n_checks++;
        if ({Timeout, StallCnt, FlushCnt} !== {1'b0, {(2*CNT_W){1'b0}}}) begin
            n_fail++; $display("FAIL rst_wait_regs: got to=%b sc=%0d fc=%0d expected 0", Timeout, StallCnt, FlushCnt);
        end
        idle();
        n_checks++;
        if (act !== C_IDLE) begin n_fail++; $display("FAIL rst_wait_state: got %b expected %b", act, C_IDLE); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < MAXC + 5; i++) begin
            drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < MAXC + 5; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (StallCnt !== 4'(MAXC) || FlushCnt !== 4'(MAXC)) begin
            n_fail++; $display("FAIL saturate: got sc=%0d fc=%0d expected %0d", StallCnt, FlushCnt, MAXC);
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom), ($urandom_range(2) != 0), 5'($urandom_range(3)),
                  ($urandom_range(7) == 0), ($urandom_range(11) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(2) != 0));
            e = exp_ctrl();
            n_checks++;
            if (act !== e) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, act, e); end
            tick();
            n_checks++;
            if (LoadUse !== m_lu || Timeout !== m_to || StallCnt !== CNT_W'(m_sc) || FlushCnt !== CNT_W'(m_fc)) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: got lu=%b to=%b sc=%0d fc=%0d expected lu=%b to=%b sc=%0d fc=%0d",
                         i, LoadUse, Timeout, StallCnt, FlushCnt, m_lu, m_to, m_sc, m_fc);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Rs_ID = 5'd0; Rt_ID = 5'd0; UsesRt_ID = 1'b0; MemRead_EX = 1'b0;
        Rt_EX = 5'd0; BranchTaken_EX = 1'b0; Jump_EX = 1'b0; MemReq_MEM = 1'b0; MemReady_MEM = 1'b0;
        m_waiting = 1'b0; m_waited = 0; m_lu = 1'b0; m_to = 1'b0; m_sc = 0; m_fc = 0;
        repeat (2) @(posedge Clk);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and stall scheduler for the 5-stage MIPS pipeline.
- Drives the stall/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC write enable.
- Resolves three conditions: data-memory wait, taken branch/jump redirect, and load-use.
- Sits beside the decode stage and consumes register IDs and control bits from ID and EX, plus the data-memory handshake from MEM.

Parameters:
- REG_W, 5, register-specifier width.
- WAIT_LIMIT, 64, maximum MEM_WAIT cycles before the timeout error is raised.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- Clk  in  1  pipeline clock; state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Rs_ID  in  REG_W  rs of the instruction in ID.
- Rt_ID  in  REG_W  rt of the instruction in ID.
- UsesRt_ID  in  1  the ID instruction reads rt as a source.
- MemRead_EX  in  1  the EX instruction is a load.
- Rt_EX  in  REG_W  load destination in EX.
- BranchTaken_EX  in  1  branch resolved taken in EX.
- Jump_EX  in  1  jump in EX.
- MemReq_MEM  in  1  MEM stage issues a data-memory access.
- MemReady_MEM  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- Stall_IF_ID  out  1  hold the IF/ID register.
- Flush_IF_ID  out  1  clear the IF/ID register.
- Stall_ID_EX  out  1  hold the ID/EX register.
- Flush_ID_EX  out  1  clear the ID/EX register.
- Stall_EX_MEM  out  1  hold the EX/MEM register.
- LoadUse  out  1  registered: a load-use bubble was inserted last cycle.
- Timeout  out  1  sticky memory-timeout error.
- StallCnt  out  CNT_W  saturating count of stall cycles.
- FlushCnt  out  CNT_W  saturating count of redirect flushes.

Behaviour:
- All control outputs are combinational from the current state and inputs (Mealy). LoadUse, Timeout, the counters and the state are registered.
- Reset, checked on the rising Clk edge:
  - state goes to RUN; wait counter = 0; LoadUse, Timeout, StallCnt, FlushCnt = 0.
  - While Reset is high, all stall/flush outputs are 0 and PCWrite = 1.
- Default (no hazard): PCWrite=1; all stall and flush outputs 0.
- States: RUN, MEM_WAIT.
- Priority within a cycle, highest first: memory wait > redirect > load-use.
- RUN, memory wait:
  - Condition: MemReq_MEM & !MemReady_MEM.
  - Outputs: PCWrite=0; Stall_IF_ID=Stall_ID_EX=Stall_EX_MEM=1; no flushes.
  - Next state: MEM_WAIT; wait counter loads 1.
  - A simultaneous redirect or load-use is not acted on; those inputs are held by the stalled pipeline and are re-evaluated after the wait.
- RUN, redirect:
  - Condition: BranchTaken_EX | Jump_EX.
  - Outputs: Flush_IF_ID=1, Flush_ID_EX=1, PCWrite=1; FlushCnt increments.
  - Load-use is suppressed because the ID instruction is squashed.
- RUN, load-use:
  - Condition: MemRead_EX & Rt_EX!=0 & (Rt_EX==Rs_ID | (UsesRt_ID & Rt_EX==Rt_ID)).
  - Outputs: PCWrite=0, Stall_IF_ID=1, Flush_ID_EX=1 (one bubble).
  - LoadUse register = 1 next cycle, otherwise 0.
  - Exactly one bubble per load, since the load leaves EX on the next edge.
- MEM_WAIT:
  - Same outputs as the memory-wait stall.
  - Wait counter increments each cycle.
  - Exits to RUN in the cycle MemReady_MEM=1; that cycle's outputs are the RUN evaluation with the memory term cleared (zero-cycle release).
  - If the counter reaches WAIT_LIMIT: Timeout sets (sticky until Reset) and the state forces to RUN, releasing the pipeline.
- StallCnt increments on every cycle with PCWrite=0.
- Both counters saturate at all-ones and never wrap.
- Flush overrides stall on the same register; this cannot occur by construction, and an assertion checks it.
- Reset asserted mid-MEM_WAIT abandons the wait immediately.

Decomposition:
- Shared package (mips_pkg): state enum {RUN, MEM_WAIT}, REG_W, and a hazard_ctrl_t struct bundling PCWrite and the stall/flush bits.
- One natural sub-module: sat_counter (CNT_W-wide saturating counter with increment enable and synchronous clear), instantiated twice.

Test Plan:
- Load-use:
  - Stimulus: MemRead_EX=1, Rt_EX=5, Rs_ID=5 for one cycle.
  - Response: PCWrite=0, Stall_IF_ID=1, Flush_ID_EX=1 for exactly 1 cycle; LoadUse=1 the next cycle; StallCnt=1.
- Load to $0 or non-source rt:
  - Stimulus: Rt_EX=0 matching Rs_ID=0, or Rt_EX=7=Rt_ID with UsesRt_ID=0.
  - Response: no stall, PCWrite=1.
- Redirect:
  - Stimulus: BranchTaken_EX=1 together with a load-use match.
  - Response: Flush_IF_ID=Flush_ID_EX=1, PCWrite=1, no stall; FlushCnt=1.
- Memory wait:
  - Stimulus: MemReq_MEM=1, MemReady_MEM low for 3 cycles, then high.
  - Response: all stalls high and PCWrite=0 for 3 cycles; release in the ready cycle; StallCnt=3.
- Timeout:
  - Stimulus: WAIT_LIMIT=4, MemReady_MEM never asserted.
  - Response: Timeout=1 after the 4th wait cycle; state returns to RUN; Timeout stays 1 until Reset.
- Reset mid-wait:
  - Stimulus: Reset asserted during MEM_WAIT.
  - Response: next cycle state RUN, counters 0, PCWrite=1, all stalls 0.
